// File: rtl/apb_slave_regs.sv
// APB completer with a bank of DEPTH 32-bit registers and WAIT_CYCLES wait states per access.
// Define APB_SLVERR_EN to add the PSLVERR port for out-of-range accesses.
module apb_slave_regs #(
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
`ifdef APB_SLVERR_EN
    output logic        PSLVERR,
`endif
    output logic        PREADY
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_next;
    logic [31:0]   regs [DEPTH];
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          oor_q;
    logic [3:0]    cnt;
    logic          paddr_ok;
    logic          setup;
    logic          complete;

    assign paddr_ok = {24'b0, PADDR} < 32'(DEPTH);
    // DONE accepts a new SETUP exactly like IDLE, giving back-to-back transfers.
    assign setup    = (state != ACCESS) && PSEL && !PENABLE;
    assign PREADY   = (state == ACCESS) && (cnt == 4'(WAIT_CYCLES));
    assign complete = (state == ACCESS) && PSEL && PENABLE && PREADY;
    assign PRDATA   = rdata_q;
`ifdef APB_SLVERR_EN
    assign PSLVERR  = PREADY && oor_q;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (setup) state_next = ACCESS;
            end
            ACCESS: begin
                if (!PSEL)         state_next = IDLE;
                else if (complete) state_next = DONE;
            end
            DONE: begin
                if (setup)                  state_next = ACCESS;
                else if (!(PSEL && PENABLE)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            oor_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
        end else begin
            state <= state_next;
            if (setup) begin
                addr_q  <= PADDR[AW-1:0];
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                oor_q   <= !paddr_ok;
                cnt     <= '0;
                rdata_q <= (!PWRITE && paddr_ok) ? regs[PADDR[AW-1:0]] : 32'h0;
            end else if (state == ACCESS) begin
                // Read data is only visible while the access phase lasts.
                if (state_next != ACCESS)          rdata_q <= 32'h0;
                else if (cnt != 4'(WAIT_CYCLES))   cnt     <= cnt + 4'd1;
            end
            if (complete && write_q && !oor_q) regs[addr_q] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: one instance with no wait states, one with three.
module tb_apb_slave_regs;
    logic        clk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic        dut_sel = 1'b0;

    logic [31:0] prdata0, prdata3, prdata_s;
    logic        pready0, pready3, pready_s;
    logic        pslverr0, pslverr3, pslverr_s;
    logic        psel0, psel3;

    int compared = 0;
    int mismatched = 0;

`ifdef APB_SLVERR_EN
    localparam logic SLVERR = 1'b1;
`else
    localparam logic SLVERR = 1'b0;
    assign pslverr0 = 1'b0;
    assign pslverr3 = 1'b0;
`endif

    assign psel0     = psel && !dut_sel;
    assign psel3     = psel && dut_sel;
    assign prdata_s  = dut_sel ? prdata3 : prdata0;
    assign pready_s  = dut_sel ? pready3 : pready0;
    assign pslverr_s = dut_sel ? pslverr3 : pslverr0;

    always #5 clk = ~clk;

    apb_slave_regs #(.DEPTH(16), .WAIT_CYCLES(0), .RESET_VAL(32'h0)) u_dut0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0),
`ifdef APB_SLVERR_EN
        .PSLVERR(pslverr0),
`endif
        .PREADY(pready0)
    );

    apb_slave_regs #(.DEPTH(16), .WAIT_CYCLES(3), .RESET_VAL(32'h0)) u_dut3 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata3),
`ifdef APB_SLVERR_EN
        .PSLVERR(pslverr3),
`endif
        .PREADY(pready3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts right after an active edge. Address/data are scrambled once the access
    // phase begins, so every transfer also exercises the SETUP-time capture.
    task automatic apb_xfer(input logic dut, input logic wr, input logic [7:0] addr,
                            input logic [31:0] data, input logic hold, input logic keep,
                            output logic [31:0] rdata, output int waits, output logic err);
        logic got;
        got = 1'b0;
        rdata = 'x;
        err = 'x;
        waits = 0;
        dut_sel = dut;
        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr = ~addr;
        pwdata = ~data;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pready_s) begin
                got = 1'b1;
                rdata = prdata_s;
                err = pslverr_s;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        if (!got) begin
            compared++;
            mismatched++;
            $error("FAIL timeout: observed no PREADY expected PREADY within 40 cycles");
        end
        @(posedge clk); #1;
        if (hold) begin
            @(negedge clk);
            check("pready_in_done", {31'b0, pready_s}, 32'h0);
            @(posedge clk); #1;
        end
        if (!keep) begin
            psel = 1'b0;
            penable = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1 preset = 1'b0;
        @(negedge clk);
        check("reset_pready", {31'b0, pready0}, 32'h0);
        check("reset_prdata", prdata0, 32'h0);
        idle_cycle();

        apb_xfer(1'b0, 1'b0, 8'd1, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("rd1_reset_data", rd, 32'h0);
        check("rd1_reset_waits", 32'(w), 32'd0);
        check("rd1_reset_err", {31'b0, er}, 32'h0);
        idle_cycle();

        apb_xfer(1'b0, 1'b1, 8'd1, 32'h11223344, 1'b1, 1'b0, rd, w, er);
        check("wr1_prdata_zero", rd, 32'h0);
        check("wr1_waits", 32'(w), 32'd0);
        check("wr1_err", {31'b0, er}, 32'h0);
        idle_cycle();
        @(negedge clk);
        check("idle_prdata", prdata0, 32'h0);
        idle_cycle();
        apb_xfer(1'b0, 1'b0, 8'd1, 32'h0, 1'b1, 1'b0, rd, w, er);
        check("rd1_data", rd, 32'h11223344);
        idle_cycle();

        apb_xfer(1'b0, 1'b1, 8'd4, 32'h12344321, 1'b1, 1'b0, rd, w, er);
        idle_cycle();
        apb_xfer(1'b0, 1'b0, 8'd4, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("rd4_data", rd, 32'h12344321);
        idle_cycle();
        apb_xfer(1'b0, 1'b0, 8'd2, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("rd2_untouched", rd, 32'h0);
        idle_cycle();

        // Three wait states.
        apb_xfer(1'b1, 1'b1, 8'd2, 32'h11112222, 1'b0, 1'b0, rd, w, er);
        check("wr2_ws_waits", 32'(w), 32'd3);
        idle_cycle();
        apb_xfer(1'b1, 1'b0, 8'd2, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("rd2_ws_data", rd, 32'h11112222);
        check("rd2_ws_waits", 32'(w), 32'd3);
        idle_cycle();

        // Out of range index.
        apb_xfer(1'b0, 1'b1, 8'h20, 32'hDEADBEEF, 1'b0, 1'b0, rd, w, er);
        check("oor_wr_err", {31'b0, er}, {31'b0, SLVERR});
        idle_cycle();
        apb_xfer(1'b0, 1'b0, 8'h20, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("oor_rd_data", rd, 32'h0);
        check("oor_rd_err", {31'b0, er}, {31'b0, SLVERR});
        idle_cycle();
        apb_xfer(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("oor_rd0_untouched", rd, 32'h0);
        idle_cycle();
        apb_xfer(1'b0, 1'b0, 8'd1, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("oor_rd1_untouched", rd, 32'h11223344);
        idle_cycle();

        // PSEL+PENABLE without a SETUP phase is ignored.
        dut_sel = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd6; pwdata = 32'h66666666;
        repeat (2) begin
            @(negedge clk);
            check("nosetup_pready", {31'b0, pready0}, 32'h0);
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        idle_cycle();
        apb_xfer(1'b0, 1'b0, 8'd6, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("nosetup_rd6", rd, 32'h0);
        idle_cycle();

        // PSEL dropped during wait states.
        dut_sel = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd5; pwdata = 32'hAAAA5555;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_pready", {31'b0, pready3}, 32'h0);
        idle_cycle();
        apb_xfer(1'b1, 1'b0, 8'd5, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("abort_rd5", rd, 32'h0);
        idle_cycle();

        // Back-to-back write then read with no idle cycle.
        apb_xfer(1'b0, 1'b1, 8'd7, 32'hCAFEF00D, 1'b0, 1'b1, rd, w, er);
        apb_xfer(1'b0, 1'b0, 8'd7, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("b2b_rd7_data", rd, 32'hCAFEF00D);
        check("b2b_rd7_waits", 32'(w), 32'd0);
        idle_cycle();

        // Reset during the access phase of a write.
        dut_sel = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 32'h12233344;
        @(posedge clk); #1;
        penable = 1'b1;
        preset = 1'b1;
        @(negedge clk);
        check("rst_mid_pready_before", {31'b0, pready0}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_pready_after", {31'b0, pready0}, 32'h0);
        check("rst_mid_prdata_after", prdata0, 32'h0);
        check("rst_mid_err_after", {31'b0, pslverr0}, 32'h0);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        idle_cycle();
        apb_xfer(1'b0, 1'b0, 8'd3, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("rst_mid_rd3", rd, 32'h0);
        idle_cycle();
        apb_xfer(1'b0, 1'b0, 8'd1, 32'h0, 1'b0, 1'b0, rd, w, er);
        check("rst_mid_rd1_cleared", rd, 32'h0);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
